timer_share_scheduler: RTL and testbench

- APB master that time-shares one system_timer instance between N_CLIENTS requesters.
- Each client asks for a one-shot delay. The block arbitrates round-robin, programs the timer's LOAD and CTRL registers, waits for INTR, clears STATUS (W1C), then pulses done to the owning client.
- Sits between client logic (e.g. watchdog, sleep and retry engines) and the timer's APB slave port.
- Write-only master; it never reads PRDATA.

---
 rtl/timer_share_scheduler.sv | 171 +++++++++++++++++
 tb/tb_timer_share_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_scheduler.sv
// Round-robin APB write master that time-shares one system_timer between N_CLIENTS one-shot delay requesters.
// Optional feature: define TIMER_SHARE_CANCEL_EN to let an owner abort its pending delay by dropping req.
module timer_share_scheduler #(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PRESC_EN   = 0,
  parameter int PRESC_DIV  = 0
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [N_CLIENTS-1:0]            req,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] delay,
  output logic [N_CLIENTS-1:0]            done,
  output logic                            busy,
  output logic [2:0]                      owner,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [3:0]                      PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  input  logic                            PREADY,
  input  logic                            INTR
);

  localparam logic [3:0]  ADDR_CTRL   = 4'h0;
  localparam logic [3:0]  ADDR_LOAD   = 4'h4;
  localparam logic [3:0]  ADDR_STATUS = 4'hC;
  localparam logic [7:0]  DIV8        = 8'(PRESC_DIV);
  localparam logic [31:0] CTRL_WORD   = {16'h0, DIV8, 5'b0, (PRESC_EN != 0), 1'b0, 1'b1};
  localparam logic [31:0] STATUS_WORD = 32'h5;

  typedef enum logic [3:0] {
    IDLE, LOAD_S, LOAD_A, CTRL_S, CTRL_A, WAIT, CLR_S, CLR_A, DONE
`ifdef TIMER_SHARE_CANCEL_EN
    , STOP_S, STOP_A
`endif
  } state_t;

  state_t                  state, state_nxt;
  logic [2:0]              owner_q, rr_last, grant_idx;
  logic                    grant_found;
  logic [DATA_WIDTH-1:0]   dly_q;
  logic [7:0]              req_pad;
  logic [DATA_WIDTH-1:0]   dly_arr [8];
  logic                    psel, penable;
  logic [3:0]              paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
`ifdef TIMER_SHARE_CANCEL_EN
  logic                    cancel_q;
`endif

  // Pad the client vectors to 8 entries so a 3-bit index always selects in range.
  assign req_pad = 8'(req);

  for (genvar g = 0; g < 8; g++) begin : g_dly
    if (g < N_CLIENTS) begin : g_used
      assign dly_arr[g] = delay[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign dly_arr[g] = '0;
    end
  end

  always_comb begin
    logic [3:0] sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      sum = {1'b0, rr_last} + 4'(k);
      if (sum >= 4'(N_CLIENTS)) sum = sum - 4'(N_CLIENTS);
      if (!grant_found && req_pad[sum[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    case (state)
      IDLE:   if (grant_found) state_nxt = LOAD_S;
      LOAD_S: begin
        psel = 1'b1; paddr = ADDR_LOAD; pwdata = dly_q;
        state_nxt = LOAD_A;
      end
      LOAD_A: begin
        psel = 1'b1; penable = 1'b1; paddr = ADDR_LOAD; pwdata = dly_q;
        if (PREADY) state_nxt = CTRL_S;
      end
      CTRL_S: begin
        psel = 1'b1; paddr = ADDR_CTRL; pwdata = DATA_WIDTH'(CTRL_WORD);
        state_nxt = CTRL_A;
      end
      CTRL_A: begin
        psel = 1'b1; penable = 1'b1; paddr = ADDR_CTRL; pwdata = DATA_WIDTH'(CTRL_WORD);
        if (PREADY) state_nxt = WAIT;
      end
      // A timeout in the same cycle as a cancel still completes normally.
      WAIT: begin
        if (INTR) state_nxt = CLR_S;
`ifdef TIMER_SHARE_CANCEL_EN
        else if (!req_pad[owner_q]) state_nxt = STOP_S;
`endif
      end
      CLR_S: begin
        psel = 1'b1; paddr = ADDR_STATUS; pwdata = DATA_WIDTH'(STATUS_WORD);
        state_nxt = CLR_A;
      end
      CLR_A: begin
        psel = 1'b1; penable = 1'b1; paddr = ADDR_STATUS; pwdata = DATA_WIDTH'(STATUS_WORD);
`ifdef TIMER_SHARE_CANCEL_EN
        if (PREADY) state_nxt = cancel_q ? IDLE : DONE;
`else
        if (PREADY) state_nxt = DONE;
`endif
      end
      DONE:   state_nxt = IDLE;
`ifdef TIMER_SHARE_CANCEL_EN
      STOP_S: begin
        psel = 1'b1; paddr = ADDR_CTRL;
        state_nxt = STOP_A;
      end
      STOP_A: begin
        psel = 1'b1; penable = 1'b1; paddr = ADDR_CTRL;
        if (PREADY) state_nxt = CLR_S;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // The delay is captured at grant so the timer sees a stable LOAD value.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      owner_q <= '0;
      rr_last <= 3'(N_CLIENTS - 1);
      dly_q   <= '0;
`ifdef TIMER_SHARE_CANCEL_EN
      cancel_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_found) begin
        owner_q <= grant_idx;
        rr_last <= grant_idx;
        dly_q   <= dly_arr[grant_idx];
`ifdef TIMER_SHARE_CANCEL_EN
        cancel_q <= 1'b0;
`endif
      end
`ifdef TIMER_SHARE_CANCEL_EN
      if (state == WAIT && state_nxt == STOP_S) cancel_q <= 1'b1;
`endif
    end
  end

  assign PSEL    = psel;
  assign PENABLE = penable;
  assign PWRITE  = psel;
  assign PADDR   = paddr;
  assign PWDATA  = pwdata;
  assign busy    = (state != IDLE);
  assign owner   = owner_q;
  assign done    = (state == DONE) ? N_CLIENTS'(8'b1 << owner_q) : '0;

endmodule

// File: tb/tb_timer_share_scheduler.sv
// Self-checking bench for timer_share_scheduler: plays clients and timer slave against a transaction-level model.
`timescale 1ns/1ps
module tb_timer_share_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   delay;
  logic              PREADY, INTR;
  logic [N-1:0]      done, done_p;
  logic              busy, busy_p;
  logic [2:0]        owner, owner_p;
  logic              PSEL, psel_p, PENABLE, penable_p, PWRITE, pwrite_p;
  logic [3:0]        PADDR, paddr_p;
  logic [DW-1:0]     PWDATA, pwdata_p;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]      req_model;
  logic [DW-1:0]     dly_model [N];
  int                rr_model;

  timer_share_scheduler #(.N_CLIENTS(N), .DATA_WIDTH(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .delay(delay), .done(done), .busy(busy),
    .owner(owner), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .INTR(INTR)
  );

  // Lockstep twin with the prescaler configured; only its CTRL data differs.
  timer_share_scheduler #(.N_CLIENTS(N), .DATA_WIDTH(DW), .PRESC_EN(1), .PRESC_DIV(3)) dut_p (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .delay(delay), .done(done_p), .busy(busy_p),
    .owner(owner_p), .PSEL(psel_p), .PENABLE(penable_p), .PWRITE(pwrite_p), .PADDR(paddr_p),
    .PWDATA(pwdata_p), .PREADY(PREADY), .INTR(INTR)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    req = req_model;
    for (int i = 0; i < N; i++) delay[i*DW +: DW] = dly_model[i];
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr_model + k) % N;
      if (req_model[idx]) return idx;
    end
    return 0;
  endfunction

  // Entered at a negedge; checks one APB write with `waits` low-PREADY access cycles, ends on the completing posedge.
  task automatic apbWrite(input string tag, input logic [3:0] addr, input logic [31:0] data,
                          input logic [31:0] data_p, input int waits, input int bound);
    int n = 0;
    while (PSEL !== 1'b1 && n < bound) begin
      @(posedge PCLK); @(negedge PCLK); n++;
    end
    checkOutput({tag, "_psel"}, 32'(PSEL), 1);
    checkOutput({tag, "_penable_setup"}, 32'(PENABLE), 0);
    checkOutput({tag, "_pwrite"}, 32'(PWRITE), 1);
    checkOutput({tag, "_paddr"}, 32'(PADDR), 32'(addr));
    checkOutput({tag, "_pwdata"}, PWDATA, data);
    checkOutput({tag, "_pwdata_presc"}, pwdata_p, data_p);
    for (int c = 0; c <= waits; c++) begin
      @(posedge PCLK); @(negedge PCLK);
      checkOutput({tag, "_access_psel"}, 32'(PSEL), 1);
      checkOutput({tag, "_access_penable"}, 32'(PENABLE), 1);
      checkOutput({tag, "_access_paddr"}, 32'(PADDR), 32'(addr));
      checkOutput({tag, "_access_pwdata"}, PWDATA, data);
      PREADY = (c == waits);
    end
    @(posedge PCLK);
  endtask

  task automatic serveFront(input int own, input logic [31:0] dly, input int wl, input int wc);
    @(negedge PCLK);
    checkOutput("owner", 32'(owner), 32'(own));
    checkOutput("busy", 32'(busy), 1);
    apbWrite("load", 4'h4, dly, dly, wl, 0);
    @(negedge PCLK);
    apbWrite("ctrl", 4'h0, 32'h1, 32'h0000_0305, wc, 0);
  endtask

  task automatic serveBack(input int own, input int ws, input int intr_dly);
    @(negedge PCLK);
    checkOutput("wait_psel", 32'(PSEL), 0);
    checkOutput("wait_done", 32'(done), 0);
    repeat (intr_dly) begin
      @(posedge PCLK); @(negedge PCLK);
      checkOutput("wait_psel", 32'(PSEL), 0);
    end
    INTR = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    INTR = 1'b0;
    apbWrite("status", 4'hC, 32'h5, 32'h5, ws, 0);
    @(negedge PCLK);
    checkOutput("done", 32'(done), 32'(1) << own);
    checkOutput("done_presc", 32'(done_p), 32'(1) << own);
    checkOutput("busy_in_done", 32'(busy), 1);
  endtask

  task automatic serve(input int own, input int wl, input int wc, input int ws, input int intr_dly);
    serveFront(own, dly_model[own], wl, wc);
    serveBack(own, ws, intr_dly);
    rr_model = own;
  endtask

  task automatic nextIdle();
    applyStimulus();
    @(negedge PCLK);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_busy_presc", 32'(busy_p), 0);
    checkOutput("idle_done", 32'(done), 0);
    checkOutput("idle_psel", 32'(PSEL), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int own;
    PRESETn = 1'b1; PREADY = 1'b1; INTR = 1'b0;
    req_model = '0;
    for (int i = 0; i < N; i++) dly_model[i] = '0;
    rr_model = N - 1;
    applyStimulus();
    #3 PRESETn = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_owner", 32'(owner), 0);
    checkOutput("rst_psel", 32'(PSEL), 0);
    checkOutput("rst_penable", 32'(PENABLE), 0);
    checkOutput("rst_pwrite", 32'(PWRITE), 0);
    checkOutput("rst_paddr", 32'(PADDR), 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    PRESETn = 1'b1;

    $display("[TB] single client, exact latency");
    req_model = 4'b0001; dly_model[0] = 10;
    applyStimulus();
    own = pick();
    serve(own, 0, 0, 0, 6);
    req_model = '0;
    nextIdle();

    $display("[TB] wait states in LOAD_A");
    req_model = 4'b0100; dly_model[2] = 32'h1234_5678;
    applyStimulus();
    own = pick();
    serve(own, 2, 0, 0, 1);
    req_model = '0;
    nextIdle();

    $display("[TB] spurious INTR in IDLE, then delay 0");
    INTR = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    INTR = 1'b0;
    checkOutput("spurious_busy", 32'(busy), 0);
    checkOutput("spurious_psel", 32'(PSEL), 0);
    req_model = 4'b1000; dly_model[3] = 0;
    applyStimulus();
    own = pick();
    serve(own, 0, 0, 0, 0);
    req_model = '0;
    nextIdle();

    $display("[TB] round robin with all clients requesting");
    req_model = 4'b1111;
    dly_model[0] = 3; dly_model[1] = 4; dly_model[2] = 5; dly_model[3] = 6;
    applyStimulus();
    for (int t = 0; t < 5; t++) begin
      own = pick();
      serve(own, 0, 0, 0, 2);
      if (t == 4) req_model = '0;
      nextIdle();
    end

    $display("[TB] owner drops req while waiting");
    req_model = 4'b0010; dly_model[1] = 100;
    applyStimulus();
    own = pick();
    serveFront(own, dly_model[own], 0, 0);
    @(negedge PCLK);
    checkOutput("drop_wait_psel", 32'(PSEL), 0);
    repeat (4) begin @(posedge PCLK); @(negedge PCLK); end
    req_model = '0;
    applyStimulus();
`ifdef TIMER_SHARE_CANCEL_EN
    @(posedge PCLK); @(negedge PCLK);
    apbWrite("stop", 4'h0, 32'h0, 32'h0, 0, 0);
    @(negedge PCLK);
    apbWrite("cancel_clr", 4'hC, 32'h5, 32'h5, 0, 0);
    @(negedge PCLK);
    checkOutput("cancel_busy", 32'(busy), 0);
    checkOutput("cancel_done", 32'(done), 0);
    rr_model = own;
`else
    serveBack(own, 0, 3);
    rr_model = own;
    nextIdle();
`endif

    $display("[TB] randomized traffic");
    for (int it = 0; it < 14; it++) begin
      if (req_model == '0) begin
        int b;
        b = $urandom_range(0, N - 1);
        req_model[b] = 1'b1;
        dly_model[b] = $urandom_range(0, 50);
      end
      applyStimulus();
      own = pick();
      serve(own, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 5));
      req_model[own] = 1'($urandom_range(0, 1));
      if (req_model[own]) dly_model[own] = $urandom;
      for (int i = 0; i < N; i++) begin
        if (i != own && !req_model[i] && $urandom_range(0, 2) == 0) begin
          req_model[i] = 1'b1;
          dly_model[i] = $urandom_range(0, 1000);
        end
      end
      nextIdle();
    end
    req_model = '0;
    nextIdle();

    $display("[TB] reset during CTRL_A");
    req_model = 4'b0100; dly_model[2] = 7;
    applyStimulus();
    own = pick();
    @(negedge PCLK);
    checkOutput("mid_owner", 32'(owner), 32'(own));
    apbWrite("mid_load", 4'h4, 32'd7, 32'd7, 0, 0);
    @(negedge PCLK);
    PREADY = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    checkOutput("mid_penable", 32'(PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_psel", 32'(PSEL), 0);
    checkOutput("mid_rst_penable", 32'(PENABLE), 0);
    checkOutput("mid_rst_pwrite", 32'(PWRITE), 0);
    checkOutput("mid_rst_paddr", 32'(PADDR), 0);
    checkOutput("mid_rst_pwdata", PWDATA, 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_owner", 32'(owner), 0);
    checkOutput("mid_rst_psel_presc", 32'(psel_p | penable_p | pwrite_p), 0);
    checkOutput("mid_rst_paddr_presc", 32'(paddr_p), 0);
    req_model = '0;
    applyStimulus();
    PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rr_model = N - 1;

    $display("[TB] priority restarts at client 0 after reset");
    req_model = 4'b0101; dly_model[0] = 9; dly_model[2] = 11;
    applyStimulus();
    own = pick();
    serve(own, 0, 1, 1, 2);
    checkOutput("post_rst_owner_presc", 32'(owner_p), 32'(own));
    req_model = '0;
    nextIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
